// File: rtl/brick_pkg.sv
// Shared definitions for the brick field: geometry, widths, the redraw entry
// layout, the controller state type and small coordinate-to-cell helpers.
package brick_pkg;

    localparam int unsigned BRICK_W_LOG2 = 5;   // brick width 32 px
    localparam int unsigned BRICK_H_LOG2 = 3;   // brick height 8 px
    localparam int unsigned COLS         = 10;
    localparam int unsigned ROWS         = 8;
    localparam int unsigned CELLS        = ROWS * COLS;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned HEALTH_W     = 2;
    localparam int unsigned IDX_W        = $clog2(CELLS);

    typedef logic [COORD_W-1:0]  coord_t;
    typedef logic [HEALTH_W-1:0] health_t;
    typedef logic [IDX_W-1:0]    idx_t;

    typedef struct packed {
        coord_t  x;
        coord_t  y;
        health_t health;
    } redraw_t;

    typedef enum logic {S_INIT, S_RUN} state_t;

    function automatic logic in_field(input coord_t x, input coord_t y);
        return (32'(x >> BRICK_W_LOG2) < COLS) && (32'(y >> BRICK_H_LOG2) < ROWS);
    endfunction

    // Only meaningful when in_field() holds for the same coordinate.
    function automatic idx_t cell_idx(input coord_t x, input coord_t y);
        int unsigned i;
        i = 32'(y >> BRICK_H_LOG2) * COLS + 32'(x >> BRICK_W_LOG2);
        return idx_t'(i);
    endfunction

    function automatic coord_t origin_x(input coord_t x);
        return (x >> BRICK_W_LOG2) << BRICK_W_LOG2;
    endfunction

    function automatic coord_t origin_y(input coord_t y);
        return (y >> BRICK_H_LOG2) << BRICK_H_LOG2;
    endfunction

endpackage

// File: rtl/brick_redraw_fifo.sv
// Redraw request queue with two push ports per cycle and drop-on-full.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   push1/data1          first push (always takes the first free slot)
//   push2/data2          second push, stored behind data1 when both push
//   valid/head/ready     valid/ready read side; head stable until popped
//   overflow             sticky, set when any push found no free slot
module brick_redraw_fifo import brick_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    push1,
    input  redraw_t data1,
    input  logic    push2,
    input  redraw_t data2,
    output logic    valid,
    output redraw_t head,
    input  logic    ready,
    output logic    overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    redraw_t mem [DEPTH];
    ptr_t    rd_ptr;
    ptr_t    wr_ptr;
    cnt_t    count;

    logic pop;
    cnt_t free;
    logic acc1;
    logic acc2;

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        pop  = valid && ready;
        // Slots freed by this cycle's pop are usable by this cycle's pushes.
        free = cnt_t'(DEPTH) - count + cnt_t'(pop);
        acc1 = push1 && (free != '0);
        acc2 = push2 && (acc1 ? (free >= cnt_t'(2)) : (free != '0));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc1) mem[wr_ptr] <= data1;
            if (acc2) mem[wr_ptr + ptr_t'(acc1)] <= data2;
            wr_ptr <= wr_ptr + ptr_t'(acc1) + ptr_t'(acc2);
            rd_ptr <= rd_ptr + ptr_t'(pop);
            count  <= count - cnt_t'(pop) + cnt_t'(acc1) + cnt_t'(acc2);
            if ((push1 && !acc1) || (push2 && !acc2)) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/brick_map.sv
// Brick-field store: answers ball probes with the containing cell's origin
// and health (1-cycle latency), applies hits, counts remaining bricks and
// queues redraw requests for the VGA drawer.
// Optional macro BRICK_SCORE_EN enables the saturating score counter;
// otherwise score is tied to 0.
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   memx/memy -> brickx/bricky/health   registered probe lookup
//   collided_k, col_xk, col_yk      hit reports (k = 1, 2; port 1 has priority)
//   ready                           field initialised
//   draw_valid/x/y/health, draw_ready   redraw queue read side
//   bricks_left, all_cleared, overflow, score   status
module brick_map import brick_pkg::*; #(
    parameter logic [1:0]  INIT_HEALTH = 2'd3,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [9:0]  memx,
    input  logic [9:0]  memy,
    output logic [9:0]  brickx,
    output logic [9:0]  bricky,
    output logic [1:0]  health,
    input  logic        collided_1,
    input  logic [9:0]  col_x1,
    input  logic [9:0]  col_y1,
    input  logic        collided_2,
    input  logic [9:0]  col_x2,
    input  logic [9:0]  col_y2,
    output logic        ready,
    output logic        draw_valid,
    output logic [9:0]  draw_x,
    output logic [9:0]  draw_y,
    output logic [1:0]  draw_health,
    input  logic        draw_ready,
    output logic [6:0]  bricks_left,
    output logic        all_cleared,
    output logic        overflow,
    output logic [15:0] score
);

    state_t  state;
    idx_t    idx;
    health_t cells [CELLS];

    logic    in1, in2, inp;
    idx_t    i1, i2, ip;
    health_t h1, h2, new1, new2;
    logic    acc1, acc2, same_cell, zero1, zero2;
    logic [1:0] zeros;
    redraw_t e1, e2, head;

    always_comb begin
        in1  = in_field(col_x1, col_y1);
        in2  = in_field(col_x2, col_y2);
        inp  = in_field(memx, memy);
        i1   = in1 ? cell_idx(col_x1, col_y1) : '0;
        i2   = in2 ? cell_idx(col_x2, col_y2) : '0;
        ip   = inp ? cell_idx(memx, memy) : '0;
        h1   = cells[i1];
        h2   = cells[i2];
        new1 = h1 - 2'd1;
        new2 = h2 - 2'd1;
        same_cell = in1 && in2 && (i1 == i2);
        acc1 = (state == S_RUN) && collided_1 && in1 && (h1 != '0);
        // A same-cell double hit is serviced by port 1 alone.
        acc2 = (state == S_RUN) && collided_2 && in2 && (h2 != '0)
               && !(collided_1 && same_cell);
        zero1 = acc1 && (new1 == '0);
        zero2 = acc2 && (new2 == '0);
        zeros = {1'b0, zero1} + {1'b0, zero2};
        e1 = '{x: origin_x(col_x1), y: origin_y(col_y1), health: new1};
        e2 = '{x: origin_x(col_x2), y: origin_y(col_y2), health: new2};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_INIT;
            idx         <= '0;
            brickx      <= '0;
            bricky      <= '0;
            health      <= '0;
            bricks_left <= '0;
        end else begin
            brickx <= origin_x(memx);
            bricky <= origin_y(memy);
            // Reads the pre-hit value, so a same-edge hit is not visible yet.
            health <= (state == S_RUN && inp) ? cells[ip] : '0;
            case (state)
                S_INIT: begin
                    cells[idx] <= INIT_HEALTH;
                    idx        <= idx + idx_t'(1);
                    if (idx == idx_t'(CELLS - 1)) begin
                        state       <= S_RUN;
                        bricks_left <= 7'(CELLS);
                    end
                end
                S_RUN: begin
                    if (acc1) cells[i1] <= new1;
                    if (acc2) cells[i2] <= new2;
                    bricks_left <= (bricks_left >= 7'(zeros)) ? bricks_left - 7'(zeros) : '0;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign ready       = (state == S_RUN);
    assign all_cleared = ready && (bricks_left == '0);

    brick_redraw_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push1    (acc1),
        .data1    (e1),
        .push2    (acc2),
        .data2    (e2),
        .valid    (draw_valid),
        .head     (head),
        .ready    (draw_ready),
        .overflow (overflow)
    );

    assign draw_x      = head.x;
    assign draw_y      = head.y;
    assign draw_health = head.health;

`ifdef BRICK_SCORE_EN
    logic [3:0]  score_inc;
    logic [16:0] score_sum;

    always_comb begin
        score_inc = (acc1 ? (zero1 ? 4'd5 : 4'd1) : 4'd0)
                  + (acc2 ? (zero2 ? 4'd5 : 4'd1) : 4'd0);
        score_sum = {1'b0, score} + 17'(score_inc);
    end

    always_ff @(posedge clk) begin
        if (!resetn) score <= '0;
        else         score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_brick_map.sv
module tb_brick_map;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  memx, memy, col_x1, col_y1, col_x2, col_y2;
    logic        collided_1, collided_2, draw_ready;
    logic [9:0]  brickx, bricky, draw_x, draw_y;
    logic [1:0]  health, draw_health;
    logic        ready, draw_valid, all_cleared, overflow;
    logic [6:0]  bricks_left;
    logic [15:0] score;

    always #5 clk = ~clk;

    brick_map dut (
        .clk(clk), .resetn(resetn), .memx(memx), .memy(memy),
        .brickx(brickx), .bricky(bricky), .health(health),
        .collided_1(collided_1), .col_x1(col_x1), .col_y1(col_y1),
        .collided_2(collided_2), .col_x2(col_x2), .col_y2(col_y2),
        .ready(ready), .draw_valid(draw_valid), .draw_x(draw_x), .draw_y(draw_y),
        .draw_health(draw_health), .draw_ready(draw_ready),
        .bricks_left(bricks_left), .all_cleared(all_cleared),
        .overflow(overflow), .score(score)
    );

    // Reference model: field as a plain array of healths, queue as a list.
    typedef struct {int x; int y; int h;} ent_t;
    int   m_h [80];
    ent_t m_q [$];
    bit   m_run, m_ovf;
    int   m_init, m_left, m_score;
    int   e_bx, e_by, e_h;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic model_hit(input bit v, input int x, input int y);
        int c, r, i;
        c = x / 32;
        r = y / 8;
        if (!v || c >= 10 || r >= 8) return;
        i = r * 10 + c;
        if (m_h[i] == 0) return;
        m_h[i]--;
        if (m_h[i] == 0) m_left--;
        m_score += (m_h[i] == 0) ? 5 : 1;
        if (m_score > 65535) m_score = 65535;
        if (m_q.size() < 4) m_q.push_back('{c * 32, r * 8, m_h[i]});
        else m_ovf = 1;
    endtask

    task automatic model_edge();
        int px, py;
        if (!resetn) begin
            m_run = 0; m_ovf = 0; m_init = 0; m_left = 0; m_score = 0;
            e_bx = 0; e_by = 0; e_h = 0;
            m_q.delete();
            foreach (m_h[i]) m_h[i] = 0;
            return;
        end
        px = int'(memx);
        py = int'(memy);
        e_bx = (px / 32) * 32;
        e_by = (py / 8) * 8;
        e_h  = (m_run && px / 32 < 10 && py / 8 < 8) ? m_h[(py / 8) * 10 + px / 32] : 0;
        if (draw_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (!m_run) begin
            m_init++;
            if (m_init == 80) begin
                m_run = 1;
                m_left = 80;
                foreach (m_h[i]) m_h[i] = 3;
            end
        end else begin
            model_hit(collided_1, int'(col_x1), int'(col_y1));
            if (!(collided_1 && int'(col_x1) / 32 == int'(col_x2) / 32
                  && int'(col_y1) / 8 == int'(col_y2) / 8))
                model_hit(collided_2, int'(col_x2), int'(col_y2));
        end
    endtask

    task automatic check_all();
        check("ready", 32'(ready), 32'(m_run));
        check("bricks_left", 32'(bricks_left), m_left);
        check("all_cleared", 32'(all_cleared), 32'(m_run && m_left == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("draw_valid", 32'(draw_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("draw_x", 32'(draw_x), m_q[0].x);
            check("draw_y", 32'(draw_y), m_q[0].y);
            check("draw_health", 32'(draw_health), m_q[0].h);
        end
        check("brickx", 32'(brickx), e_bx);
        check("bricky", 32'(bricky), e_by);
        check("health", 32'(health), e_h);
`ifdef BRICK_SCORE_EN
        check("score", 32'(score), m_score);
`else
        check("score", 32'(score), 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        collided_1 = 0; collided_2 = 0;
        col_x1 = 0; col_y1 = 0; col_x2 = 0; col_y2 = 0;
    endtask

    task automatic hit1(input int x, input int y);
        collided_1 = 1; col_x1 = 10'(x); col_y1 = 10'(y);
    endtask

    task automatic hit2(input int x, input int y);
        collided_2 = 1; col_x2 = 10'(x); col_y2 = 10'(y);
    endtask

    task automatic probe(input int x, input int y);
        memx = 10'(x); memy = 10'(y);
    endtask

    initial begin
        int n, guard, i;
        resetn = 0; draw_ready = 0;
        idle();
        probe(0, 0);
        step(); step();
        check("rst_ready", 32'(ready), 0);
        check("rst_bricks_left", 32'(bricks_left), 0);
        check("rst_score", 32'(score), 0);

        // Init sweep length
        resetn = 1;
        n = 0;
        while (!ready && n < 200) begin step(); n++; end
        check("init_cycles", n, 80);
        check("init_bricks_left", 32'(bricks_left), 80);

        probe(40, 12); step();
        check("probe_bx", 32'(brickx), 32);
        check("probe_by", 32'(bricky), 8);
        check("probe_h", 32'(health), 3);

        // Four hits on one cell; the fourth finds it empty
        draw_ready = 1;
        probe(45, 13);
        for (int k = 0; k < 4; k++) begin
            hit1(45, 13); step();
            check("hitseq_lookup", 32'(health), 3 - k);
            check("hitseq_valid", 32'(draw_valid), 32'(k < 3));
            if (k < 3) check("hitseq_draw_h", 32'(draw_health), 2 - k);
        end
        idle(); step();
        check("hitseq_left", 32'(bricks_left), 79);

        // Dual hit on distinct cells, order port 1 then port 2
        draw_ready = 0;
        hit1(0, 0); hit2(64, 0); step();
        idle(); step();
        check("dual_first_x", 32'(draw_x), 0);
        draw_ready = 1; step();
        check("dual_second_x", 32'(draw_x), 64);
        probe(0, 0); step();
        probe(64, 0); step();
        check("dual_cell_b", 32'(health), 2);

        // Dual hit on the same cell counts once
        draw_ready = 0;
        hit1(5, 5); hit2(5, 5); step();
        idle(); step();
        check("same_draw_h", 32'(draw_health), 1);
        draw_ready = 1; step();
        check("same_single_entry", 32'(draw_valid), 0);

        // Six hits into a stalled queue
        draw_ready = 0;
        for (int k = 0; k < 3; k++) begin
            hit1(2 * k * 32 + 3, 27); hit2((2 * k + 1) * 32 + 3, 27); step();
        end
        idle(); step();
        check("ovf_set", 32'(overflow), 1);
        for (int k = 0; k < 6; k++) begin
            probe(k * 32 + 7, 30); step();
            check("ovf_cell_dec", 32'(health), 2);
        end
        draw_ready = 1;
        for (int k = 0; k < 5; k++) step();

        // Outside the field
        probe(330, 70); step();
        check("oof_h", 32'(health), 0);
        check("oof_bx", 32'(brickx), 320);
        probe(100, 70); step();
        check("oof_row_h", 32'(health), 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            probe(int'($urandom_range(0, 399)), int'($urandom_range(0, 79)));
            collided_1 = ($urandom_range(0, 2) == 0);
            collided_2 = ($urandom_range(0, 2) == 0);
            col_x1 = 10'($urandom_range(0, 399)); col_y1 = 10'($urandom_range(0, 79));
            col_x2 = ($urandom_range(0, 3) == 0) ? col_x1 : 10'($urandom_range(0, 399));
            col_y2 = ($urandom_range(0, 3) == 0) ? col_y1 : 10'($urandom_range(0, 79));
            draw_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        // Clear the whole field
        draw_ready = 1;
        guard = 0;
        for (int c = 0; c < 80; c++) begin
            while (m_h[c] > 0 && guard < 2000) begin
                idle();
                hit1((c % 10) * 32 + int'($urandom_range(0, 31)),
                     (c / 10) * 8 + int'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) begin
                    i = int'($urandom_range(0, 79));
                    hit2((i % 10) * 32 + 1, (i / 10) * 8 + 1);
                end
                step();
                guard++;
            end
        end
        check("clear_guard", 32'(guard < 2000), 1);
        idle();
        for (int k = 0; k < 6; k++) step();
        check("cleared", 32'(all_cleared), 1);
        check("cleared_left", 32'(bricks_left), 0);
`ifdef BRICK_SCORE_EN
        check("final_score", 32'(score), 560);
`else
        check("final_score", 32'(score), 0);
`endif

        // Reset mid-play
        resetn = 0; step();
        check("rst2_ready", 32'(ready), 0);
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_valid", 32'(draw_valid), 0);
        check("rst2_score", 32'(score), 0);
        resetn = 1;
        for (int k = 0; k < 3; k++) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
